car_motor_drv: RTL and testbench
================================

CAR_MOTOR_DRV -- requirements
Module: car_motor_drv

Interface
REQ-001 Parameter TURN_CYCLES, default 8, SHALL set the number of cycles a turn is driven (legal range 1..255).
REQ-002 Parameter PWM_PERIOD, default 16, SHALL set the forward-PWM period in cycles (legal range 2..256).
REQ-003 Parameter FWD_DUTY, default 12, SHALL set the high cycles per PWM period in forward motion (legal range 0..PWM_PERIOD).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset; asynchronous and active-low.
REQ-006 go_front  input  1  steering command: drive forward.
REQ-007 go_left  input  1  steering command: turn left.
REQ-008 go_right  input  1  steering command: turn right.
REQ-009 motor_l_en  output  1  left motor enable.
REQ-010 motor_l_dir  output  1  left motor direction: 1 = forward, 0 = reverse.
REQ-011 motor_r_en  output  1  right motor enable.
REQ-012 motor_r_dir  output  1  right motor direction: 1 = forward, 0 = reverse.
REQ-013 busy  output  1  high while a turn or settle is in progress; commands are ignored while high.
REQ-014 cmd_err  output  1  one-cycle pulse when more than one go_* is high at a sample edge.

Function
REQ-015 All outputs SHALL be registered and SHALL change on the same edge as the state register.
REQ-016 States SHALL be IDLE, FWD, TURN_L, TURN_R and SETTLE.
REQ-017 IDLE: both enables 0, both dir 1, busy 0.
REQ-018 From IDLE or FWD, with busy 0, the go_* inputs sampled at edge k SHALL select the state for edge k as follows:
- go_front only: FWD.
- go_left only: TURN_L.
- go_right only: TURN_R.
- none: IDLE.
REQ-019 If two or more go_* inputs are high at a sampled edge, cmd_err SHALL pulse for one cycle and the next state SHALL be IDLE.
REQ-020 FWD behaviour:
- both dir 1;
- both enables = (pwm_cnt < FWD_DUTY);
- pwm_cnt counts 0..PWM_PERIOD-1, then wraps to 0;
- pwm_cnt is 0 in the first FWD cycle.
REQ-021 FWD_DUTY=0 SHALL keep both enables 0 in FWD; FWD_DUTY=PWM_PERIOD SHALL keep both enables 1.
REQ-022 TURN_L: motor_l_dir 0, motor_r_dir 1, both enables 1, busy 1. TURN_R: the mirror image (motor_l_dir 1, motor_r_dir 0).
REQ-023 A turn SHALL last exactly TURN_CYCLES cycles (turn_cnt 0..TURN_CYCLES-1), then go to SETTLE for exactly 1 cycle (both enables 0, busy 1), then to IDLE.
REQ-024 go_* inputs SHALL be ignored while in TURN_L, TURN_R or SETTLE, including multi-hot combinations (no cmd_err).
REQ-025 A new command present at the edge leaving SETTLE SHALL NOT be acted on; it is acted on at the following edge, from IDLE.
REQ-026 Holding go_front from FWD SHALL keep the state in FWD with pwm_cnt running uninterrupted.

Reset
REQ-027 While rst_n is 0, regardless of clk: state IDLE; pwm_cnt and turn_cnt 0; motor_l_en 0, motor_r_en 0; motor_l_dir 1, motor_r_dir 1; busy 0; cmd_err 0.
REQ-028 Reset asserted mid-turn SHALL abort the turn immediately and take effect asynchronously.
REQ-029 After rst_n deasserts, the first command SHALL be sampled at the first rising edge.

Structure
REQ-030 Shared package car_pkg SHALL hold:
- the state enum;
- DIR_FWD=1 and DIR_REV=0 constants;
- default parameter constants.
REQ-031 PWM counter and compare SHALL be a sub-module car_pwm (inputs clk, rst_n, run; output pwm_out).
REQ-032 Counter widths SHALL be derived from PWM_PERIOD and TURN_CYCLES via $clog2.

Verification
REQ-033 Reset test: assert rst_n=0 mid-TURN_L, between clock edges -> all enables 0 and busy 0 before the next edge.
REQ-034 Forward PWM: go_front=1 held for 32 cycles (defaults) -> enables high cycles 0-11, low cycles 12-15, repeated twice; both dir 1.
REQ-035 Left turn: 1-cycle go_left pulse -> TURN_L for 8 cycles (l_dir 0, r_dir 1, enables 1, busy 1), SETTLE for 1 cycle, then IDLE.
REQ-036 Ignored command: go_right during cycle 3 of TURN_L -> no effect; go_right present at the edge leaving SETTLE -> TURN_R entered one edge later.
REQ-037 Illegal command: go_front=1 and go_left=1 together from FWD -> cmd_err=1 for one cycle, state IDLE, enables 0.
REQ-038 Edge parameters: FWD_DUTY=0 and FWD_DUTY=16 with go_front held -> enables constant 0 and constant 1 respectively.

Source files
------------

// File: rtl/car_pkg.sv
// ---------------------------------------------------------------------------
// car_pkg -- shared definitions for the car motor driver.
//   state_t          : controller states (IDLE, FWD, TURN_L, TURN_R, SETTLE)
//   DIR_FWD/DIR_REV  : motor direction encodings
//   DEF_*            : default parameter values
//   multi_hot()      : true when two or more steering commands are active
// ---------------------------------------------------------------------------
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_TURN_L = 3'd2,
    ST_TURN_R = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int DEF_TURN_CYCLES = 8;
  localparam int DEF_PWM_PERIOD  = 16;
  localparam int DEF_FWD_DUTY    = 12;

  function automatic logic multi_hot(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/car_motor_drv_if.sv
// ---------------------------------------------------------------------------
// car_motor_drv_if -- steering commands in, motor drive and status out.
//   go_front/go_left/go_right : steering commands (driven by the master)
//   motor_l_en/motor_l_dir    : left motor enable / direction (1 = forward)
//   motor_r_en/motor_r_dir    : right motor enable / direction (1 = forward)
//   busy                      : turn or settle in progress, commands ignored
//   cmd_err                   : one-cycle pulse on a multi-hot command
// ---------------------------------------------------------------------------
interface car_motor_drv_if;
  logic go_front;
  logic go_left;
  logic go_right;
  logic motor_l_en;
  logic motor_l_dir;
  logic motor_r_en;
  logic motor_r_dir;
  logic busy;
  logic cmd_err;

  modport master (
    output go_front, go_left, go_right,
    input  motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, busy, cmd_err
  );

  modport slave (
    input  go_front, go_left, go_right,
    output motor_l_en, motor_l_dir, motor_r_en, motor_r_dir, busy, cmd_err
  );
endinterface

// File: rtl/car_pwm.sv
// ---------------------------------------------------------------------------
// car_pwm -- forward-motion PWM generator.
//   clk     : clock
//   rst_n   : asynchronous active-low reset
//   run     : high when the controller will be in FWD after this edge
//   pwm_out : registered PWM level for the cycle following the edge
// The counter restarts at 0 on the first FWD cycle and keeps running while
// run stays high on consecutive edges.
// ---------------------------------------------------------------------------
module car_pwm
  import car_pkg::*;
#(
  parameter int PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int FWD_DUTY   = DEF_FWD_DUTY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic pwm_out
);

  localparam int CNT_W = $clog2(PWM_PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             active;

  // Count value that will be current after the edge; a fresh FWD entry
  // (active low last cycle) starts the period from zero.
  always_comb begin
    cnt_nxt = '0;
    if (run && active) begin
      cnt_nxt = (cnt == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      active  <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      active  <= run;
      pwm_out <= run && (int'(cnt_nxt) < FWD_DUTY);
    end
  end

endmodule

// File: rtl/car_motor_drv.sv
// ---------------------------------------------------------------------------
// car_motor_drv -- steering controller for a two-motor car.
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : car_motor_drv_if.slave (go_* commands in, motor drive/status out)
// Commands are acted on from IDLE/FWD only. A turn drives both motors in
// opposite directions for TURN_CYCLES cycles, then a one-cycle SETTLE with
// motors off precedes the return to IDLE.
// ---------------------------------------------------------------------------
module car_motor_drv
  import car_pkg::*;
#(
  parameter int TURN_CYCLES = DEF_TURN_CYCLES,
  parameter int PWM_PERIOD  = DEF_PWM_PERIOD,
  parameter int FWD_DUTY    = DEF_FWD_DUTY
) (
  input  logic           clk,
  input  logic           rst_n,
  car_motor_drv_if.slave bus
);

  localparam int TC_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  state_t          state;
  state_t          state_nxt;
  logic [TC_W-1:0] turn_cnt;
  logic [TC_W-1:0] turn_cnt_nxt;
  logic            err_nxt;

  logic turn_en_q;
  logic l_dir_q;
  logic r_dir_q;
  logic busy_q;
  logic err_q;
  logic pwm_out;
  logic pwm_run;

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = '0;
    err_nxt      = 1'b0;
    case (state)
      ST_IDLE, ST_FWD: begin
        if (multi_hot(bus.go_front, bus.go_left, bus.go_right)) begin
          state_nxt = ST_IDLE;
          err_nxt   = 1'b1;
        end else if (bus.go_front) begin
          state_nxt = ST_FWD;
        end else if (bus.go_left) begin
          state_nxt = ST_TURN_L;
        end else if (bus.go_right) begin
          state_nxt = ST_TURN_R;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_TURN_L, ST_TURN_R: begin
        if (turn_cnt == TC_W'(TURN_CYCLES - 1)) begin
          state_nxt = ST_SETTLE;
        end else begin
          turn_cnt_nxt = turn_cnt + TC_W'(1);
        end
      end
      // Commands seen on the edge leaving SETTLE are deliberately dropped.
      ST_SETTLE: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they update on the same
  // edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      turn_cnt  <= '0;
      turn_en_q <= 1'b0;
      l_dir_q   <= DIR_FWD;
      r_dir_q   <= DIR_FWD;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      turn_cnt  <= turn_cnt_nxt;
      turn_en_q <= (state_nxt == ST_TURN_L) || (state_nxt == ST_TURN_R);
      l_dir_q   <= (state_nxt == ST_TURN_L) ? DIR_REV : DIR_FWD;
      r_dir_q   <= (state_nxt == ST_TURN_R) ? DIR_REV : DIR_FWD;
      busy_q    <= (state_nxt == ST_TURN_L) || (state_nxt == ST_TURN_R) ||
                   (state_nxt == ST_SETTLE);
      err_q     <= err_nxt;
    end
  end

  assign pwm_run = (state_nxt == ST_FWD);

  car_pwm #(
    .PWM_PERIOD (PWM_PERIOD),
    .FWD_DUTY   (FWD_DUTY)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (pwm_run),
    .pwm_out (pwm_out)
  );

  // turn_en_q and pwm_out are both flops and never high together, so the
  // OR only changes at clock edges (or asynchronously to 0 on reset).
  assign bus.motor_l_en  = turn_en_q | pwm_out;
  assign bus.motor_r_en  = turn_en_q | pwm_out;
  assign bus.motor_l_dir = l_dir_q;
  assign bus.motor_r_dir = r_dir_q;
  assign bus.busy        = busy_q;
  assign bus.cmd_err     = err_q;

endmodule

// File: tb/tb_car_motor_drv.sv
// ---------------------------------------------------------------------------
// tb_car_motor_drv -- self-checking bench for car_motor_drv.
// Three instances share the same commands: default duty (12), duty 0 and
// duty 16. A behavioural model tracks time-in-forward and remaining busy
// cycles per instance and predicts every output once per cycle.
// ---------------------------------------------------------------------------
module tb_car_motor_drv;

  localparam int TURN = 8;
  localparam int PER  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go_front = 1'b0;
  logic go_left = 1'b0;
  logic go_right = 1'b0;

  always #5 clk = ~clk;

  car_motor_drv_if bus0 ();
  car_motor_drv_if bus1 ();
  car_motor_drv_if bus2 ();

  assign bus0.go_front = go_front;
  assign bus0.go_left  = go_left;
  assign bus0.go_right = go_right;
  assign bus1.go_front = go_front;
  assign bus1.go_left  = go_left;
  assign bus1.go_right = go_right;
  assign bus2.go_front = go_front;
  assign bus2.go_left  = go_left;
  assign bus2.go_right = go_right;

  car_motor_drv #(.TURN_CYCLES(TURN), .PWM_PERIOD(PER), .FWD_DUTY(12))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  car_motor_drv #(.TURN_CYCLES(TURN), .PWM_PERIOD(PER), .FWD_DUTY(0))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  car_motor_drv #(.TURN_CYCLES(TURN), .PWM_PERIOD(PER), .FWD_DUTY(16))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [2:0] o_len, o_ren, o_ldir, o_rdir, o_busy, o_err;
  assign o_len  = {bus2.motor_l_en,  bus1.motor_l_en,  bus0.motor_l_en};
  assign o_ren  = {bus2.motor_r_en,  bus1.motor_r_en,  bus0.motor_r_en};
  assign o_ldir = {bus2.motor_l_dir, bus1.motor_l_dir, bus0.motor_l_dir};
  assign o_rdir = {bus2.motor_r_dir, bus1.motor_r_dir, bus0.motor_r_dir};
  assign o_busy = {bus2.busy,        bus1.busy,        bus0.busy};
  assign o_err  = {bus2.cmd_err,     bus1.cmd_err,     bus0.cmd_err};

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state per instance.
  int duty[3] = '{12, 0, 16};
  int busy_left[3];   // busy cycles remaining, including the current one
  int fwd_age[3];     // cycles spent in forward so far (0 = first)
  bit in_fwd[3];
  bit turn_right[3];
  bit err_now[3];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      busy_left[i]  = 0;
      fwd_age[i]    = 0;
      in_fwd[i]     = 0;
      turn_right[i] = 0;
      err_now[i]    = 0;
    end
  endtask

  task automatic model_step(input logic f, input logic l, input logic r);
    int hot;
    hot = int'(f) + int'(l) + int'(r);
    for (int i = 0; i < 3; i++) begin
      err_now[i] = 0;
      if (busy_left[i] > 0) begin
        busy_left[i]--;
      end else if (hot > 1) begin
        err_now[i] = 1;
        in_fwd[i]  = 0;
      end else if (f) begin
        fwd_age[i] = in_fwd[i] ? fwd_age[i] + 1 : 0;
        in_fwd[i]  = 1;
      end else if (l || r) begin
        busy_left[i]  = TURN + 1;
        turn_right[i] = r;
        in_fwd[i]     = 0;
      end else begin
        in_fwd[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    int en, ld, rd;
    for (int i = 0; i < 3; i++) begin
      if (busy_left[i] > 1)       en = 1;
      else if (busy_left[i] == 1) en = 0;
      else if (in_fwd[i])         en = ((fwd_age[i] % PER) < duty[i]) ? 1 : 0;
      else                        en = 0;
      chk($sformatf("l_en[%0d]", i), int'(o_len[i]), en);
      chk($sformatf("r_en[%0d]", i), int'(o_ren[i]), en);
      chk($sformatf("busy[%0d]", i), int'(o_busy[i]), (busy_left[i] > 0) ? 1 : 0);
      chk($sformatf("cmd_err[%0d]", i), int'(o_err[i]), int'(err_now[i]));
      // Direction during SETTLE is not defined, so it is left unchecked.
      if (busy_left[i] != 1) begin
        ld = (busy_left[i] > 1 && !turn_right[i]) ? 0 : 1;
        rd = (busy_left[i] > 1 &&  turn_right[i]) ? 0 : 1;
        chk($sformatf("l_dir[%0d]", i), int'(o_ldir[i]), ld);
        chk($sformatf("r_dir[%0d]", i), int'(o_rdir[i]), rd);
      end
    end
  endtask

  // Called at a negedge: drive, let the DUT sample, check at next negedge.
  task automatic cycle(input logic f, input logic l, input logic r);
    go_front = f;
    go_left  = l;
    go_right = r;
    @(posedge clk);
    model_step(f, l, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [2:0] g;
    int guard;
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    @(negedge clk);

    // First command after reset is taken on the first edge.
    cycle(1, 0, 0);
    chk("fwd_first_en", int'(o_len[0]), 1);

    // Forward PWM held 32 cycles (including the one above).
    for (int k = 1; k < 32; k++) begin
      cycle(1, 0, 0);
      chk("duty0_en", int'(o_len[1]), 0);
      chk("duty16_en", int'(o_len[2]), 1);
    end

    // Multi-hot from forward.
    cycle(1, 1, 0);
    chk("multi_err", int'(o_err[0]), 1);
    cycle(0, 0, 0);
    chk("err_pulse_1cyc", int'(o_err[0]), 0);

    // Left turn pulse, right command in cycle 3, right at SETTLE exit.
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    cycle(1, 1, 1);
    guard = 0;
    while (busy_left[0] != 1 && guard < 20) begin
      cycle(0, 0, 0);
      guard++;
    end
    chk("reach_settle", guard < 20 ? 1 : 0, 1);
    cycle(0, 0, 1);
    chk("settle_exit_ignored", int'(o_busy[0]), 0);
    cycle(0, 0, 1);
    chk("turn_r_entered", int'(o_rdir[0]), 0);
    repeat (12) cycle(0, 0, 0);

    // Randomised command stream.
    g = 3'b000;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) > 4) begin
        case ($urandom_range(0, 7))
          0, 1, 2: g = 3'b100;
          3:       g = 3'b010;
          4:       g = 3'b001;
          5:       g = 3'($urandom_range(0, 7));
          default: g = 3'b000;
        endcase
      end
      cycle(g[2], g[1], g[0]);
    end

    // Asynchronous reset in the middle of a left turn.
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    go_left = 1'b0;
    @(posedge clk);
    model_step(0, 0, 0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 1);
    chk("post_reset_turn", int'(o_busy[0]), 1);
    repeat (12) cycle(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
